nibbler_sequencer: RTL and testbench

Instruction sequencer for the Nibbler 4-bit CPU. It owns the 12-bit program counter, instruction register, operand-address register and carry/zero flags. It steps every instruction through FETCH, optional ADDR and EXEC states, and drives the load/select/strobe controls of the accumulator A, the ALU, data memory and the I/O ports. The program ROM is asynchronous and 8 bits wide, addressed by `pc`.

---
 rtl/nibbler_sequencer_if.sv | 34 +++
 rtl/nibbler_sequencer.sv | 178 +++++++++++++++++
 tb/tb_nibbler_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibbler_sequencer_if.sv
// Nibbler sequencer bus: ROM/ALU status in, datapath controls out.
// master = sequencer, slave = datapath/ROM/memory side.
interface nibbler_sequencer_if;
  logic        run;
  logic [7:0]  instr;
  logic        alu_c;
  logic        alu_z;
  logic [11:0] pc;
  logic [3:0]  imm;
  logic [11:0] mem_addr;
  logic [1:0]  alu_op;
  logic [1:0]  b_sel;
  logic        a_load;
  logic        mem_we;
  logic        out_we;
  logic        in_re;
  logic        c_flag;
  logic        z_flag;
  logic        busy;

  modport master (
    input  run, instr, alu_c, alu_z,
    output pc, imm, mem_addr, alu_op, b_sel,
    output a_load, mem_we, out_we, in_re,
    output c_flag, z_flag, busy
  );

  modport slave (
    output run, instr, alu_c, alu_z,
    input  pc, imm, mem_addr, alu_op, b_sel,
    input  a_load, mem_we, out_we, in_re,
    input  c_flag, z_flag, busy
  );
endinterface

// File: rtl/nibbler_sequencer.sv
// Nibbler 4-bit CPU sequencer: FETCH -> [ADDR] -> EXEC.
// Ports: clk, reset (async, active-low), bus (master modport).
module nibbler_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  nibbler_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ADDR  = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  localparam logic [3:0] OP_JC   = 4'h0;
  localparam logic [3:0] OP_JNC  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_JNZ  = 4'h3;
  localparam logic [3:0] OP_CMPI = 4'h4;
  localparam logic [3:0] OP_CMPM = 4'h5;
  localparam logic [3:0] OP_LIT  = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_ADDM = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_NORI = 4'hE;
  localparam logic [3:0] OP_NORM = 4'hF;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [11:0] addr_q, addr_d;
  logic        c_q, c_d;
  logic        z_q, z_d;

  logic [3:0]  op;
  logic        take;
  logic        a_load, mem_we, out_we, in_re;
  logic [1:0]  alu_op, b_sel;

  assign op = ir_q[7:4];

  function automatic logic two_byte(input logic [3:0] o);
    unique case (o)
      OP_JC, OP_JNC, OP_JZ, OP_JNZ,
      OP_CMPM, OP_LD, OP_ST, OP_ADDM,
      OP_JMP, OP_NORM: two_byte = 1'b1;
      default:         two_byte = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    c_d     = c_q;
    z_d     = z_q;
    take    = 1'b0;
    a_load  = 1'b0;
    mem_we  = 1'b0;
    out_we  = 1'b0;
    in_re   = 1'b0;
    alu_op  = 2'b00;
    b_sel   = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          ir_d    = bus.instr;
          pc_d    = pc_q + 12'd1;
          state_d = two_byte(bus.instr[7:4]) ? S_ADDR : S_EXEC;
        end
      end
      S_ADDR: begin
        addr_d  = {ir_q[3:0], bus.instr};
        pc_d    = pc_q + 12'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (op)
          OP_JC:   take = c_q;
          OP_JNC:  take = !c_q;
          OP_JZ:   take = z_q;
          OP_JNZ:  take = !z_q;
          OP_JMP:  take = 1'b1;
          OP_CMPI: begin
            alu_op = 2'b10;
            c_d    = bus.alu_c;
            z_d    = bus.alu_z;
          end
          OP_CMPM: begin
            alu_op = 2'b10;
            b_sel  = 2'b01;
            c_d    = bus.alu_c;
            z_d    = bus.alu_z;
          end
          OP_LIT:  a_load = 1'b1;
          OP_IN: begin
            a_load = 1'b1;
            in_re  = 1'b1;
            b_sel  = 2'b10;
          end
          OP_LD: begin
            a_load = 1'b1;
            b_sel  = 2'b01;
          end
          OP_ST:   mem_we = 1'b1;
          OP_ADDI: begin
            a_load = 1'b1;
            alu_op = 2'b01;
            c_d    = bus.alu_c;
            z_d    = bus.alu_z;
          end
          OP_ADDM: begin
            a_load = 1'b1;
            alu_op = 2'b01;
            b_sel  = 2'b01;
            c_d    = bus.alu_c;
            z_d    = bus.alu_z;
          end
          OP_OUT:  out_we = 1'b1;
          OP_NORI: begin
            a_load = 1'b1;
            alu_op = 2'b11;
            z_d    = bus.alu_z;
          end
          OP_NORM: begin
            a_load = 1'b1;
            alu_op = 2'b11;
            b_sel  = 2'b01;
            z_d    = bus.alu_z;
          end
          default: ;
        endcase
        // not-taken jumps leave pc already past the operand byte
        if (take) pc_d = addr_q;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.imm      = ir_q[3:0];
  assign bus.mem_addr = addr_q;
  assign bus.alu_op   = alu_op;
  assign bus.b_sel    = b_sel;
  assign bus.a_load   = a_load;
  assign bus.mem_we   = mem_we;
  assign bus.out_we   = out_we;
  assign bus.in_re    = in_re;
  assign bus.c_flag   = c_q;
  assign bus.z_flag   = z_q;
  assign bus.busy     = (state_q != S_FETCH);

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Bench for nibbler_sequencer: program table + hand sequences.
// Expected EXEC results flow through a scoreboard queue.
module tb_nibbler_sequencer;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        ac;
    logic        az;
    logic [3:0]  strb;
    logic [1:0]  op;
    logic [1:0]  bs;
    logic        ec;
    logic        ez;
    logic [11:0] npc;
  } vec_t;

  logic clk;
  logic reset;
  logic [7:0] rom [4096];
  vec_t tbl [19];
  vec_t exp_q [$];
  int total;
  int bad;

  nibbler_sequencer_if bus ();

  nibbler_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr = rom[bus.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic tb_two(input logic [3:0] o);
    case (o)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5,
      4'h8, 4'h9, 4'hB, 4'hC, 4'hF: tb_two = 1'b1;
      default:                    tb_two = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] strobes();
    strobes = {bus.a_load, bus.mem_we, bus.out_we, bus.in_re};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_instr(input vec_t v);
    vec_t e;
    logic two;
    two = tb_two(v.b0[7:4]);
    chk("fetch_pc", 32'(bus.pc), 32'(v.addr));
    chk("fetch_busy", 32'(bus.busy), 32'd0);
    chk("fetch_strb", 32'(strobes()), 32'd0);
    bus.run   = 1'b1;
    bus.alu_c = v.ac;
    bus.alu_z = v.az;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    if (two) begin
      chk("addr_busy", 32'(bus.busy), 32'd1);
      chk("addr_strb", 32'(strobes()), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk("exec_busy", 32'(bus.busy), 32'd1);
    chk("exec_strb", 32'(strobes()), 32'(e.strb));
    chk("exec_alu_op", 32'(bus.alu_op), 32'(e.op));
    chk("exec_b_sel", 32'(bus.b_sel), 32'(e.bs));
    chk("exec_imm", 32'(bus.imm), 32'(e.b0[3:0]));
    if (two)
      chk("exec_mem_addr", 32'(bus.mem_addr),
          32'({e.b0[3:0], e.b1}));
    bus.run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("next_pc", 32'(bus.pc), 32'(e.npc));
    chk("c_flag", 32'(bus.c_flag), 32'(e.ec));
    chk("z_flag", 32'(bus.z_flag), 32'(e.ez));
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_strb", 32'(strobes()), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_imm", 32'(bus.imm), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_c", 32'(bus.c_flag), 32'd0);
    chk("rst_z", 32'(bus.z_flag), 32'd0);
    chk("rst_strb", 32'(strobes()), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_b_sel", 32'(bus.b_sel), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    foreach (rom[i]) rom[i] = 8'h00;

    // addr, b0, b1, alu_c, alu_z, strb{a,m,o,i}, op, bsel, c, z, next pc
    tbl[0]  = '{12'h000, 8'h63, 8'h00, 1'b1, 1'b1, 4'b1000,
                2'b00, 2'b00, 1'b0, 1'b0, 12'h001};
    tbl[1]  = '{12'h001, 8'hA5, 8'h00, 1'b1, 1'b0, 4'b1000,
                2'b01, 2'b00, 1'b1, 1'b0, 12'h002};
    tbl[2]  = '{12'h002, 8'h00, 8'h12, 1'b0, 1'b1, 4'b0000,
                2'b00, 2'b00, 1'b1, 1'b0, 12'h012};
    tbl[3]  = '{12'h012, 8'h10, 8'h40, 1'b0, 1'b1, 4'b0000,
                2'b00, 2'b00, 1'b1, 1'b0, 12'h014};
    tbl[4]  = '{12'h014, 8'hE7, 8'h00, 1'b0, 1'b1, 4'b1000,
                2'b11, 2'b00, 1'b1, 1'b1, 12'h015};
    tbl[5]  = '{12'h015, 8'h20, 8'h30, 1'b0, 1'b0, 4'b0000,
                2'b00, 2'b00, 1'b1, 1'b1, 12'h030};
    tbl[6]  = '{12'h030, 8'h91, 8'h34, 1'b0, 1'b0, 4'b0100,
                2'b00, 2'b00, 1'b1, 1'b1, 12'h032};
    tbl[7]  = '{12'h032, 8'h4A, 8'h00, 1'b0, 1'b0, 4'b0000,
                2'b10, 2'b00, 1'b0, 1'b0, 12'h033};
    tbl[8]  = '{12'h033, 8'h30, 8'h50, 1'b1, 1'b1, 4'b0000,
                2'b00, 2'b00, 1'b0, 1'b0, 12'h050};
    tbl[9]  = '{12'h050, 8'h5F, 8'hFF, 1'b1, 1'b1, 4'b0000,
                2'b10, 2'b01, 1'b1, 1'b1, 12'h052};
    tbl[10] = '{12'h052, 8'h80, 8'h07, 1'b0, 1'b0, 4'b1000,
                2'b00, 2'b01, 1'b1, 1'b1, 12'h054};
    tbl[11] = '{12'h054, 8'h70, 8'h00, 1'b0, 1'b0, 4'b1001,
                2'b00, 2'b10, 1'b1, 1'b1, 12'h055};
    tbl[12] = '{12'h055, 8'hB1, 8'h00, 1'b0, 1'b0, 4'b1000,
                2'b01, 2'b01, 1'b0, 1'b0, 12'h057};
    tbl[13] = '{12'h057, 8'hF2, 8'h22, 1'b1, 1'b1, 4'b1000,
                2'b11, 2'b01, 1'b0, 1'b1, 12'h059};
    tbl[14] = '{12'h059, 8'h00, 8'h80, 1'b1, 1'b0, 4'b0000,
                2'b00, 2'b00, 1'b0, 1'b1, 12'h05B};
    tbl[15] = '{12'h05B, 8'h20, 8'hA0, 1'b1, 1'b0, 4'b0000,
                2'b00, 2'b00, 1'b0, 1'b1, 12'h0A0};
    tbl[16] = '{12'h0A0, 8'hD0, 8'h00, 1'b1, 1'b0, 4'b0010,
                2'b00, 2'b00, 1'b0, 1'b1, 12'h0A1};
    tbl[17] = '{12'h0A1, 8'hCF, 8'hFF, 1'b1, 1'b0, 4'b0000,
                2'b00, 2'b00, 1'b0, 1'b1, 12'hFFF};
    tbl[18] = '{12'hFFF, 8'hD0, 8'h00, 1'b0, 1'b0, 4'b0010,
                2'b00, 2'b00, 1'b0, 1'b1, 12'h000};

    for (int i = 0; i < 19; i++) begin
      logic [11:0] a1;
      a1 = tbl[i].addr + 12'd1;
      rom[tbl[i].addr] = tbl[i].b0;
      if (tb_two(tbl[i].b0[7:4])) rom[a1] = tbl[i].b1;
    end

    reset     = 1'b0;
    bus.run   = 1'b0;
    bus.alu_c = 1'b0;
    bus.alu_z = 1'b0;
    #2;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_pc", 32'(bus.pc), 32'd0);

    for (int i = 0; i < 19; i++) run_instr(tbl[i]);

    // run low in FETCH: nothing moves
    bus.alu_c = 1'b1;
    bus.alu_z = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_pc", 32'(bus.pc), 32'd0);
      chk("hold_busy", 32'(bus.busy), 32'd0);
      chk("hold_imm", 32'(bus.imm), 32'd0);
      chk("hold_c", 32'(bus.c_flag), 32'd0);
      chk("hold_z", 32'(bus.z_flag), 32'd1);
    end

    // run dropped during ADDR of JMP 0x345: still completes
    rom[0] = 8'hC3;
    rom[1] = 8'h45;
    bus.run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drop_addr_busy", 32'(bus.busy), 32'd1);
    bus.run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_exec_busy", 32'(bus.busy), 32'd1);
    chk("drop_exec_addr", 32'(bus.mem_addr), 32'h345);
    @(posedge clk);
    @(negedge clk);
    chk("drop_pc", 32'(bus.pc), 32'h345);
    chk("drop_done_busy", 32'(bus.busy), 32'd0);

    // reset mid-ADDR of JMP 0x789: async return, jump abandoned
    rom[12'h345] = 8'hC7;
    rom[12'h346] = 8'h89;
    bus.run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_pc", 32'(bus.pc), 32'h346);
    #2;
    reset   = 1'b0;
    bus.run = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_pc", 32'(bus.pc), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    rom[0] = 8'h63;
    run_instr(tbl[0]);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
